cache_ctrl_nway: RTL

Parametrised N-way, write-back, write-allocate cache controller for the pipelined cache. It succeeds the fixed 4-way clean/dirty-miss controller.
- Adds per-way hit resolution and true victim selection through per-set tree-PLRU state.
- Adds explicit writeback-then-fill sequencing on the DFP side.
- Sits between the cache's tag/valid/dirty arrays, the data array write-enable mux and the memory-side (DFP) port.

---
 rtl/rv32im_types.sv | 26 ++
 rtl/plru_tree.sv | 54 +++++
 rtl/cache_ctrl_nway.sv | 118 +++++++++++
 3 files changed

// File: rtl/rv32im_types.sv
// Shared cache-controller types: data-array write-select encodings, controller
// state enum and a lowest-set-bit priority encoder.
package rv32im_types;

    localparam logic [1:0] no_write  = 2'b00;
    localparam logic [1:0] write_cpu = 2'b01;
    localparam logic [1:0] write_mem = 2'b10;

    typedef enum logic [2:0] {
        COMPARE   = 3'd0,
        WRITEBACK = 3'd1,
        FILL      = 3'd2,
        REPLAY    = 3'd3
    } cache_ctrl_state_t;

    localparam int MAX_WAYS = 64;

    // Callers zero-extend their way vector and cast the result to WAY_W.
    function automatic int lowest_set(input logic [MAX_WAYS-1:0] vec);
        lowest_set = 0;
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (vec[i]) lowest_set = i;
        end
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Per-set tree-PLRU state: heap-ordered node bits (root = bit 0, children of
// node n at 2n+1 / 2n+2), 0 = victim on the left, 1 = victim on the right.
module plru_tree #(
    parameter  int NUM_WAYS = 4,
    parameter  int NUM_SETS = 16,
    localparam int SET_W    = $clog2(NUM_SETS),
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SET_W-1:0] rd_set,
    output logic [WAY_W-1:0] victim_way,
    input  logic             upd_en,
    input  logic [SET_W-1:0] upd_set,
    input  logic [WAY_W-1:0] upd_way
);

    localparam int NODES = NUM_WAYS - 1;

    logic [NODES-1:0] tree [NUM_SETS];
    logic [NODES-1:0] rd_bits;
    logic [NODES-1:0] upd_bits;

    // The node visited at level lvl is selected by the way bits already decided.
    always_comb begin
        rd_bits    = tree[rd_set];
        victim_way = '0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            for (int p = 0; p < (1 << lvl); p++) begin
                if ((int'(victim_way) >> (WAY_W - lvl)) == p)
                    victim_way[WAY_W-1-lvl] = rd_bits[(1 << lvl) - 1 + p];
            end
        end
    end

    always_comb begin
        upd_bits = tree[upd_set];
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            for (int p = 0; p < (1 << lvl); p++) begin
                if ((int'(upd_way) >> (WAY_W - lvl)) == p)
                    upd_bits[(1 << lvl) - 1 + p] = ~upd_way[WAY_W-1-lvl];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) tree[s] <= '0;
        end else if (upd_en) begin
            tree[upd_set] <= upd_bits;
        end
    end

endmodule

// File: rtl/cache_ctrl_nway.sv
// N-way write-back / write-allocate cache controller: hit resolution, PLRU
// victim choice and writeback-then-fill sequencing on the memory port.
module cache_ctrl_nway
    import rv32im_types::*;
#(
    parameter  int NUM_WAYS = 4,
    parameter  int NUM_SETS = 16,
    localparam int SET_W    = $clog2(NUM_SETS),
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ufp_read,
    input  logic                ufp_write,
    input  logic [SET_W-1:0]    set_idx,
    input  logic [NUM_WAYS-1:0] tag_match,
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [NUM_WAYS-1:0] dirty,
    input  logic                dfp_resp,
    output logic                ufp_resp,
    output logic                hit,
    output logic [WAY_W-1:0]    hit_way,
    output logic [WAY_W-1:0]    victim_way,
    output logic                dfp_read,
    output logic                dfp_write,
    output logic [1:0]          cache_write,
    output logic [WAY_W-1:0]    write_way,
    output logic [2:0]          ctrl_state
);

    cache_ctrl_state_t state, state_nxt;

    logic [WAY_W-1:0]    victim_q, victim_nxt;
    logic [WAY_W-1:0]    plru_victim, miss_victim, upd_way;
    logic [NUM_WAYS-1:0] hit_vec;
    logic                ufp_rw, upd_en;

    assign ufp_rw  = ufp_read | ufp_write;
    assign hit_vec = tag_match & valid;

    // Filling an empty way always beats evicting a live line.
    assign miss_victim = (~&valid) ? WAY_W'(lowest_set(MAX_WAYS'(~valid))) : plru_victim;

    plru_tree #(
        .NUM_WAYS (NUM_WAYS),
        .NUM_SETS (NUM_SETS)
    ) u_plru (
        .clk        (clk),
        .rst        (rst),
        .rd_set     (set_idx),
        .victim_way (plru_victim),
        .upd_en     (upd_en),
        .upd_set    (set_idx),
        .upd_way    (upd_way)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= COMPARE;
            victim_q <= '0;
        end else begin
            state    <= state_nxt;
            victim_q <= victim_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        victim_nxt  = victim_q;
        ufp_resp    = 1'b0;
        hit         = 1'b0;
        hit_way     = '0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        cache_write = no_write;
        write_way   = '0;
        upd_en      = 1'b0;
        upd_way     = '0;
        unique case (state)
            COMPARE: begin
                if (ufp_rw) begin
                    if (hit_vec != '0) begin
                        ufp_resp    = 1'b1;
                        hit         = 1'b1;
                        hit_way     = WAY_W'(lowest_set(MAX_WAYS'(hit_vec)));
                        cache_write = ufp_write ? write_cpu : no_write;
                        write_way   = hit_way;
                        upd_en      = 1'b1;
                        upd_way     = hit_way;
                    end else begin
                        victim_nxt = miss_victim;
                        state_nxt  = (valid[miss_victim] & dirty[miss_victim]) ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                dfp_write = 1'b1;
                if (dfp_resp) state_nxt = FILL;
            end
            FILL: begin
                dfp_read = 1'b1;
                if (dfp_resp) begin
                    cache_write = write_mem;
                    write_way   = victim_q;
                    upd_en      = 1'b1;
                    upd_way     = victim_q;
                    state_nxt   = REPLAY;
                end
            end
            REPLAY:  state_nxt = COMPARE;
            default: state_nxt = COMPARE;
        endcase
    end

    assign victim_way = victim_q;
    assign ctrl_state = state;

endmodule
